// File: rtl/req_ack_rr_arbiter.sv
// rtl/req_ack_rr_arbiter.sv - round-robin req/ack arbiter with per-transaction watchdog
module req_ack_rr_arbiter #(
    parameter  int N       = 4,
    parameter  int TIMEOUT = 16,
    parameter  int CW      = 8,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   nack,
    output logic           res_req,
    output logic [IDW-1:0] res_id,
    input  logic           res_ack,
    output logic           busy,
    output logic [CW-1:0]  timeout_count
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   nack_q, nack_d;
    logic           res_req_q, res_req_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  tcount_q, tcount_d;

    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic [N-1:0]   grant_onehot;

    // Rotating priority search starting at ptr, wrapping at N (N need not be a power of two).
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int             pos;
            logic [IDW-1:0] idx;
            pos = int'(ptr_q) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IDW'(pos);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << res_id_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = '0;
        nack_d     = '0;
        res_req_d  = res_req_q;
        res_id_d   = res_id_q;
        tcount_d   = tcount_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    res_id_d   = pick_id;
                    res_req_d  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // ack has priority over a simultaneous expiry.
                if (res_ack) begin
                    ack_d     = grant_onehot;
                    res_req_d = 1'b0;
                    state_d   = DONE;
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    nack_d    = grant_onehot;
                    res_req_d = 1'b0;
                    state_d   = DONE;
                    if (tcount_q != {CW{1'b1}}) begin
                        tcount_d = tcount_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DONE: begin
                ptr_d   = (res_id_q == IDW'(N - 1)) ? '0 : res_id_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                res_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wait_cnt_q <= '0;
            ack_q      <= '0;
            nack_q     <= '0;
            res_req_q  <= 1'b0;
            res_id_q   <= '0;
            busy_q     <= 1'b0;
            tcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wait_cnt_q <= wait_cnt_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            res_req_q  <= res_req_d;
            res_id_q   <= res_id_d;
            busy_q     <= busy_d;
            tcount_q   <= tcount_d;
        end
    end

    assign ack           = ack_q;
    assign nack          = nack_q;
    assign res_req       = res_req_q;
    assign res_id        = res_id_q;
    assign busy          = busy_q;
    assign timeout_count = tcount_q;

endmodule

// File: tb/tb_req_ack_rr_arbiter.sv
// tb/tb_req_ack_rr_arbiter.sv - self-checking bench for req_ack_rr_arbiter
module tb_req_ack_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       res_ack = 1'b0;
    logic [3:0] ack, nack;
    logic       res_req, busy;
    logic [1:0] res_id;
    logic [7:0] timeout_count;

    logic [3:0] req_s = '0;
    logic       res_ack_s = 1'b0;
    logic [3:0] ack_s, nack_s;
    logic       res_req_s, busy_s;
    logic [1:0] res_id_s;
    logic [1:0] tcount_s;

    int passes = 0;
    int total  = 0;
    int ptr_m  = 0;
    int tc_m   = 0;

    req_ack_rr_arbiter #(.N(N), .TIMEOUT(TO), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .nack(nack),
        .res_req(res_req), .res_id(res_id), .res_ack(res_ack),
        .busy(busy), .timeout_count(timeout_count)
    );

    req_ack_rr_arbiter #(.N(N), .TIMEOUT(TO), .CW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req_s), .ack(ack_s), .nack(nack_s),
        .res_req(res_req_s), .res_id(res_id_s), .res_ack(res_ack_s),
        .busy(busy_s), .timeout_count(tcount_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: first set request at or after ptr in circular order.
    function automatic int pick(input logic [3:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Called at a falling edge with the arbiter idle; d is the WAIT cycle index
    // (0-based) in which res_ack is presented.
    task automatic run_txn(input logic [3:0] rq, input int d, input int want,
                           input logic [3:0] rq_after, input string tag);
        int   id;
        int   hi;
        int   exp_hi;
        logic ok;
        id      = pick(rq, ptr_m);
        req     = rq;
        res_ack = 1'($urandom % 2);
        @(negedge clk);
        check({tag, " res_req rise"}, 32'(res_req), 32'd1);
        check({tag, " res_id"}, 32'(res_id), 32'(id));
        if (want >= 0) check({tag, " order"}, 32'(res_id), 32'(want));
        hi = 0;
        while (res_req === 1'b1 && hi < TO + 4) begin
            res_ack = (hi == d);
            @(negedge clk);
            hi++;
        end
        ok     = (d <= TO - 1);
        exp_hi = ok ? d + 1 : TO;
        if (!ok) tc_m = (tc_m < 255) ? tc_m + 1 : 255;
        check({tag, " res_req cycles"}, 32'(hi), 32'(exp_hi));
        check({tag, " ack"}, 32'(ack), ok ? (32'd1 << id) : 32'd0);
        check({tag, " nack"}, 32'(nack), ok ? 32'd0 : (32'd1 << id));
        check({tag, " timeout_count"}, 32'(timeout_count), 32'(tc_m));
        check({tag, " busy done"}, 32'(busy), 32'd1);
        ptr_m   = (id + 1) % N;
        req     = rq_after;
        res_ack = 1'($urandom % 2);
        @(negedge clk);
        check({tag, " ack clear"}, 32'(ack | nack), 32'd0);
        check({tag, " busy idle"}, 32'(busy), 32'd0);
        check({tag, " res_req idle"}, 32'(res_req), 32'd0);
    endtask

    initial begin
        int n;
        int exp_tc;
        logic [3:0] rq;

        @(negedge clk);
        @(negedge clk);
        check("rst ack", 32'(ack), 32'd0);
        check("rst nack", 32'(nack), 32'd0);
        check("rst res_req", 32'(res_req), 32'd0);
        check("rst res_id", 32'(res_id), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst timeout_count", 32'(timeout_count), 32'd0);
        check("rst sat count", 32'(tcount_s), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four held, each drops its own request after its ack.
        run_txn(4'b1111, 0, 0, 4'b1110, "rr0");
        run_txn(4'b1110, 0, 1, 4'b1100, "rr1");
        run_txn(4'b1100, 0, 2, 4'b1000, "rr2");
        run_txn(4'b1000, 0, 3, 4'b0000, "rr3");
        run_txn(4'b1111, 0, 0, 4'b0000, "rr4");

        run_txn(4'b0001, 2, 0, 4'b0000, "single");
        run_txn(4'b0100, 100, 2, 4'b0000, "stuck");
        run_txn(4'b1111, 1, 3, 4'b0000, "ptr after nack");
        run_txn(4'b0100, TO - 1, 2, 4'b0000, "ack at expiry");

        for (int i = 0; i < 24; i++) begin
            rq = 4'($urandom_range(1, 15));
            run_txn(rq, int'($urandom_range(0, TO + 2)), -1, 4'b0000, "rnd");
        end

        // Reset in the middle of WAIT must clear outputs without a clock edge.
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst res_req", 32'(res_req), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst res_id", 32'(res_id), 32'd0);
        check("mid rst ack/nack", 32'(ack | nack), 32'd0);
        check("mid rst count", 32'(timeout_count), 32'd0);
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        tc_m  = 0;
        run_txn(4'b1010, 1, 1, 4'b0000, "post rst");

        // Saturating counter on the CW=2 instance.
        req_s = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (nack_s === 4'b0000 && n < 40) begin
                @(negedge clk);
                n++;
            end
            exp_tc = (i + 1 < 3) ? i + 1 : 3;
            check("sat nack", 32'(nack_s), 32'd1 << (i % N));
            check("sat count", 32'(tcount_s), 32'(exp_tc));
            @(negedge clk);
        end
        req_s = 4'b0000;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
